mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): WORD_SIZE, 32, address width; LINE_SIZE, 128, cache line width; TIMEOUT, 64, response timeout in cycles.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 ic_req / ic_req_addr  in  1 / WORD_SIZE  I-cache line read request, held high until granted.
REQ-005 dc_req / dc_req_addr  in  1 / WORD_SIZE  D-cache line read request, held high until granted.
REQ-006 dc_write / dc_write_addr / dc_write_data  in  1 / WORD_SIZE / LINE_SIZE  D-cache writeback, held high until granted.
REQ-007 ic_grant, dc_grant, dc_wgrant  out  1 each  one-cycle acceptance pulses.
REQ-008 ic_res, dc_res  out  1 each  response valid, routed to the owner of the read.
REQ-009 ic_res_addr, dc_res_addr / ic_res_data, dc_res_data  out  WORD_SIZE / LINE_SIZE  response address and line.
REQ-010 mem_req / mem_req_addr  out  1 / WORD_SIZE  memory read request, one-cycle pulse.
REQ-011 mem_write / mem_write_addr / mem_write_data  out  1 / WORD_SIZE / LINE_SIZE  memory write, one-cycle pulse.
REQ-012 mem_res / mem_res_addr / mem_res_data  in  1 / WORD_SIZE / LINE_SIZE  memory response.
REQ-013 timeout  out  1  one-cycle pulse when an outstanding read is abandoned.

Function
REQ-014 FSM states: IDLE (no read outstanding) and WAIT_RES (one read outstanding); at most one read outstanding.
REQ-015 Each cycle at most one new operation is issued: a write or a read, never both.
REQ-016 Priority: a pending dc_write wins over reads, in IDLE and in WAIT_RES.
REQ-017 In IDLE with no dc_write: one read requester is served; if both request, round-robin by last_owner, the opposite of the last served read.
REQ-018 Issue is registered: a request sampled at edge N drives the grant pulse and mem_req/mem_write plus address/data during cycle N+1.
REQ-019 A read issue latches owner and address, and moves IDLE->WAIT_RES at the same edge.
REQ-020 In WAIT_RES, when mem_res=1 and mem_res_addr equals the latched address: res/addr/data go combinationally to the owner's outputs in that cycle; next edge -> IDLE and last_owner=owner.
REQ-021 These cases are ignored, with no output and no state change: mem_res in IDLE, or mem_res with a mismatched address.
REQ-022 A requester deasserting req before grant is legal; nothing is issued for it.
REQ-023 Non-owner response outputs are 0; res_addr/res_data are 0 whenever the matching res is 0.
REQ-024 Write payload is captured at issue; dc_write_data may change after dc_wgrant.

Reset
REQ-025 rst=1 at an edge: state=IDLE, last_owner=DC (I-cache served first), timeout counter 0, all outputs 0 next cycle.
REQ-026 Reset mid-WAIT_RES discards the outstanding read; a later matching mem_res is ignored.

Configuration
REQ-027 Macro MEM_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT_RES. After TIMEOUT cycles without a matching response, pulse timeout for one cycle and move to IDLE. last_owner is unchanged.
- Undefined: timeout is tied 0 and WAIT_RES waits indefinitely.

Verification
REQ-028 ic_req=1, addr 128; memory answers 3 cycles after mem_req with addr 128, data 128'h7F -> ic_grant and mem_req at cycle+1, mem_req_addr=128; ic_res=1 with data 128'h7F; dc_res=0.
REQ-029 ic_req and dc_req both 1 from reset, addrs 128/256 -> first mem_req_addr=128; after its response, second mem_req_addr=256.
REQ-030 dc_write (addr 512, data 128'h12345678) and ic_req raised in the same cycle -> dc_wgrant/mem_write first; mem_req for the read follows 1 cycle later.
REQ-031 In WAIT_RES for addr 128: mem_res with addr 132 -> no ic_res, state stays WAIT_RES; then mem_res with addr 128 -> ic_res.
REQ-032 rst pulsed in WAIT_RES, then mem_res addr 128 -> no response output; all outputs 0.
REQ-033 MEM_ARB_TIMEOUT_EN, TIMEOUT=64, no response -> timeout=1 exactly 64 cycles after issue; next ic_req is granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single line-wide memory port between three clients: I-cache line
// reads, D-cache line reads and D-cache writebacks. At most one read is in
// flight at any time. A writeback can be issued while a read is in flight.
//
// Request/grant handshake (all three client channels):
//   A client raises its request and holds it stable, together with its
//   address and data, until it sees its one-cycle grant pulse. A request seen
//   at rising edge N produces the grant pulse during cycle N+1. The memory
//   command (mem_req or mem_write, with its address and data) is pulsed in
//   that same cycle. The client may drop its request during the grant cycle
//   or keep it up through that cycle. A request already shown a grant is
//   never served a second time. Dropping a request before it is granted is
//   legal, and nothing is then issued for it.
//   Read responses use no handshake. ic_res/dc_res is a one-cycle valid that
//   goes to the owner of the outstanding read, in the same cycle as the
//   matching mem_res.
//
// Ports
//   clk, rst                              clock, synchronous active-high reset
//   ic_req, ic_req_addr                   I-cache line read request
//   dc_req, dc_req_addr                   D-cache line read request
//   dc_write, dc_write_addr/_data         D-cache writeback request
//   ic_grant, dc_grant, dc_wgrant         one-cycle acceptance pulses
//   ic_res/_addr/_data, dc_res/_addr/_data  response, routed to the read owner
//   mem_req, mem_req_addr                 memory read command (one cycle)
//   mem_write, mem_write_addr/_data       memory write command (one cycle)
//   mem_res, mem_res_addr/_data           memory read response
//   timeout                               pulse when a read is abandoned
//   state_dbg                             FSM state (0 = IDLE, 1 = WAIT_RES)
//
// Configuration
//   MEM_ARB_TIMEOUT_EN  when defined, a read with no matching response for
//                       TIMEOUT cycles is abandoned. timeout pulses for one
//                       cycle and the FSM returns to IDLE. When undefined,
//                       timeout is tied low and the FSM waits indefinitely.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [WORD_SIZE-1:0] ic_req_addr,
  input  logic                 dc_req,
  input  logic [WORD_SIZE-1:0] dc_req_addr,
  input  logic                 dc_write,
  input  logic [WORD_SIZE-1:0] dc_write_addr,
  input  logic [LINE_SIZE-1:0] dc_write_data,
  output logic                 ic_grant,
  output logic                 dc_grant,
  output logic                 dc_wgrant,
  output logic                 ic_res,
  output logic [WORD_SIZE-1:0] ic_res_addr,
  output logic [LINE_SIZE-1:0] ic_res_data,
  output logic                 dc_res,
  output logic [WORD_SIZE-1:0] dc_res_addr,
  output logic [LINE_SIZE-1:0] dc_res_data,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_req_addr,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_write_addr,
  output logic [LINE_SIZE-1:0] mem_write_data,
  input  logic                 mem_res,
  input  logic [WORD_SIZE-1:0] mem_res_addr,
  input  logic [LINE_SIZE-1:0] mem_res_data,
  output logic                 timeout,
  output logic                 state_dbg
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RES = 1'b1
  } state_t;

  // Read owner encoding
  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  state_t               state_q;
  state_t               state_d;
  logic                 owner_q;       // owner of the outstanding read
  logic                 last_owner_q;  // owner of the last completed read
  logic [WORD_SIZE-1:0] rd_addr_q;     // address of the outstanding read

  logic                 res_match;     // matching response this cycle
  logic                 abandon;       // outstanding read times out at this edge
  logic                 issue_write;
  logic                 issue_read;
  logic                 read_pick;
  logic [WORD_SIZE-1:0] read_addr;

  // A matching response is recognised only while a read is outstanding.
  // A response with any other address, or one that arrives in IDLE, is dropped.
  assign res_match = (state_q == ST_WAIT_RES) && mem_res && (mem_res_addr == rd_addr_q);

  // -------------------------------------------------------------------------
  // Issue decision
  // -------------------------------------------------------------------------
  // The writeback takes priority. A dc_write that is showing its grant during
  // this cycle has already been served, so it is masked. This prevents a client
  // that holds the request through the grant cycle from getting a second write.
  // Because that masked write is no longer pending, a read can issue at the
  // same edge.
  always_comb begin
    issue_write = dc_write && !dc_wgrant;
    issue_read  = 1'b0;
    read_pick   = OWNER_IC;
    read_addr   = ic_req_addr;
    if ((state_q == ST_IDLE) && !issue_write) begin
      if (ic_req && dc_req) begin
        // Round-robin: serve the opposite of the last completed read
        issue_read = 1'b1;
        read_pick  = (last_owner_q == OWNER_DC) ? OWNER_IC : OWNER_DC;
      end else if (ic_req) begin
        issue_read = 1'b1;
        read_pick  = OWNER_IC;
      end else if (dc_req) begin
        issue_read = 1'b1;
        read_pick  = OWNER_DC;
      end
    end
    read_addr = (read_pick == OWNER_DC) ? dc_req_addr : ic_req_addr;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_read) state_d = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (res_match || abandon) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (response routing is combinational)
  // -------------------------------------------------------------------------
  always_comb begin
    ic_res      = 1'b0;
    ic_res_addr = '0;
    ic_res_data = '0;
    dc_res      = 1'b0;
    dc_res_addr = '0;
    dc_res_data = '0;
    if (res_match) begin
      if (owner_q == OWNER_IC) begin
        ic_res      = 1'b1;
        ic_res_addr = mem_res_addr;
        ic_res_data = mem_res_data;
      end else begin
        dc_res      = 1'b1;
        dc_res_addr = mem_res_addr;
        dc_res_data = mem_res_data;
      end
    end
  end

  assign state_dbg = state_q;

  // -------------------------------------------------------------------------
  // Read ownership and round-robin history
  // -------------------------------------------------------------------------
  // last_owner resets to DC so that on a tie the I-cache is served first.
  // Only a completed read updates it. An abandoned read leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWNER_IC;
      rd_addr_q    <= '0;
      last_owner_q <= OWNER_DC;
    end else begin
      if (issue_read) begin
        owner_q   <= read_pick;
        rd_addr_q <= read_addr;
      end
      if (res_match) begin
        last_owner_q <= owner_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered grants and memory commands
  // -------------------------------------------------------------------------
  // Address and data buses are zero whenever their command is idle. The write
  // payload is captured here, so the client can change dc_write_data as soon
  // as it sees dc_wgrant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_grant       <= 1'b0;
      dc_grant       <= 1'b0;
      dc_wgrant      <= 1'b0;
      mem_req        <= 1'b0;
      mem_req_addr   <= '0;
      mem_write      <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      dc_wgrant      <= issue_write;
      mem_write      <= issue_write;
      mem_write_addr <= issue_write ? dc_write_addr : '0;
      mem_write_data <= issue_write ? dc_write_data : '0;
      ic_grant       <= issue_read && (read_pick == OWNER_IC);
      dc_grant       <= issue_read && (read_pick == OWNER_DC);
      mem_req        <= issue_read;
      mem_req_addr   <= issue_read ? read_addr : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Response timeout
  // -------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] to_cnt_q;
  logic             timeout_q;

  // The counter holds the number of full WAIT_RES cycles already elapsed.
  // With TIMEOUT = 64, the read issued in cycle C is abandoned at the edge that
  // ends cycle C+63, and timeout is high during cycle C+64. A response that
  // matches on that final edge wins over the timeout.
  assign abandon = (state_q == ST_WAIT_RES) && !res_match &&
                   (to_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abandon;
      if ((state_q == ST_WAIT_RES) && !res_match && !abandon) begin
        to_cnt_q <= to_cnt_q + CNT_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign abandon = 1'b0;
  // The feature is compiled out. TIMEOUT stays in the parameter list and
  // only takes part in this constant-false term.
  assign timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed and randomized bench for mem_arbiter. A behavioural model tracks
// the outstanding read, the round-robin history and the command expected on
// the memory port. The model advances once per clock edge from the inputs
// sampled at that edge. Registered outputs are checked #1 after each rising
// edge. Combinational response outputs are checked mid-cycle, after the
// inputs have settled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int WORD_SIZE = 32;
  localparam int LINE_SIZE = 128;
  localparam int TIMEOUT   = 64;
  localparam int L         = LINE_SIZE;
  localparam bit IC        = 1'b0;
  localparam bit DC        = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ic_req, dc_req, dc_write;
  logic [WORD_SIZE-1:0] ic_req_addr, dc_req_addr, dc_write_addr;
  logic [LINE_SIZE-1:0] dc_write_data;
  logic                 ic_grant, dc_grant, dc_wgrant;
  logic                 ic_res, dc_res;
  logic [WORD_SIZE-1:0] ic_res_addr, dc_res_addr;
  logic [LINE_SIZE-1:0] ic_res_data, dc_res_data;
  logic                 mem_req, mem_write, mem_res;
  logic [WORD_SIZE-1:0] mem_req_addr, mem_write_addr, mem_res_addr;
  logic [LINE_SIZE-1:0] mem_write_data, mem_res_data;
  logic                 timeout, state_dbg;

  always #5 clk = ~clk;

  mem_arbiter #(.WORD_SIZE(WORD_SIZE), .LINE_SIZE(LINE_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_req_addr(ic_req_addr),
    .dc_req(dc_req), .dc_req_addr(dc_req_addr),
    .dc_write(dc_write), .dc_write_addr(dc_write_addr), .dc_write_data(dc_write_data),
    .ic_grant(ic_grant), .dc_grant(dc_grant), .dc_wgrant(dc_wgrant),
    .ic_res(ic_res), .ic_res_addr(ic_res_addr), .ic_res_data(ic_res_data),
    .dc_res(dc_res), .dc_res_addr(dc_res_addr), .dc_res_data(dc_res_data),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_res(mem_res), .mem_res_addr(mem_res_addr), .mem_res_data(mem_res_data),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;   // index of the current cycle (edges seen so far)

  // ---------------- reference model ----------------
  bit                   m_busy;
  bit                   m_owner;
  bit                   m_last;
  logic [WORD_SIZE-1:0] m_addr;
  int                   m_issue_edge;
  bit                   e_ic_grant, e_dc_grant, e_wgrant, e_mem_req, e_mem_write, e_timeout;
  logic [WORD_SIZE-1:0] e_mem_req_addr, e_mem_write_addr;
  logic [LINE_SIZE-1:0] e_mem_write_data;

  // ---------------- client / memory driver state ----------------
  bit                   ic_hold, dc_hold, w_hold;
  bit                   rand_on, resp_on, resp_rand_data;
  int                   resp_delay;     // 0 selects a random delay of 1..6
  int                   resp_bad_mode;  // 0 none, 1 always, 2 random
  int                   cd;
  bit                   cd_bad;
  logic [WORD_SIZE-1:0] cd_addr;
  logic [LINE_SIZE-1:0] resp_data;

  // ---------------- observation logs (DUT side) ----------------
  logic [WORD_SIZE-1:0] req_log[$];
  int                   req_cyc[$];
  logic [WORD_SIZE-1:0] wr_addr_log[$];
  logic [LINE_SIZE-1:0] wr_data_log[$];
  int                   wr_cyc[$];
  int                   icg_cyc[$];
  int                   to_cyc[$];
  int                   icres_cyc[$];
  logic [LINE_SIZE-1:0] icres_data[$];
  int                   dc_res_cnt;

  task automatic chk(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    req_log.delete(); req_cyc.delete(); wr_addr_log.delete(); wr_data_log.delete();
    wr_cyc.delete(); icg_cyc.delete(); to_cyc.delete(); icres_cyc.delete();
    icres_data.delete(); dc_res_cnt = 0;
  endtask

  function automatic logic [WORD_SIZE-1:0] rnd_addr();
    return WORD_SIZE'($urandom_range(0, 255)) << 4;
  endfunction

  function automatic logic [LINE_SIZE-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model step for one rising edge, using the inputs that edge samples.
  task automatic model_edge();
    bit                   hit, w, r, pick;
    logic [WORD_SIZE-1:0] raddr;
    if (rst) begin
      m_busy = 0; m_last = DC; m_owner = IC; m_addr = '0;
      e_ic_grant = 0; e_dc_grant = 0; e_wgrant = 0; e_mem_req = 0; e_mem_write = 0;
      e_timeout = 0; e_mem_req_addr = '0; e_mem_write_addr = '0; e_mem_write_data = '0;
    end else begin
      hit   = m_busy && (mem_res === 1'b1) && (mem_res_addr === m_addr);
      // a write whose grant is showing now has been served already
      w     = dc_write && !e_wgrant;
      r     = 0;
      pick  = IC;
      raddr = '0;
      if (!m_busy && !w) begin
        if (ic_req && dc_req) begin r = 1; pick = (m_last == DC) ? IC : DC; end
        else if (ic_req)      begin r = 1; pick = IC; end
        else if (dc_req)      begin r = 1; pick = DC; end
        raddr = (pick == DC) ? dc_req_addr : ic_req_addr;
      end
      e_wgrant         = w;
      e_mem_write      = w;
      e_mem_write_addr = w ? dc_write_addr : '0;
      e_mem_write_data = w ? dc_write_data : '0;
      e_ic_grant       = r && (pick == IC);
      e_dc_grant       = r && (pick == DC);
      e_mem_req        = r;
      e_mem_req_addr   = r ? raddr : '0;
      e_timeout        = 0;
      if (hit) begin
        m_busy = 0;
        m_last = m_owner;
      end else if (m_busy && TO_EN && ((cyc + 1) - m_issue_edge == TIMEOUT)) begin
        m_busy    = 0;
        e_timeout = 1;
      end
      if (r) begin
        m_busy = 1; m_owner = pick; m_addr = raddr; m_issue_edge = cyc + 1;
      end
    end
  endtask

  // Client and memory behaviour for the current cycle.
  task automatic drive();
    if (ic_hold) begin ic_req = 0; ic_hold = 0; end
    if (e_ic_grant) ic_hold = 1;
    if (dc_hold) begin dc_req = 0; dc_hold = 0; end
    if (e_dc_grant) dc_hold = 1;
    if (w_hold) begin dc_write = 0; w_hold = 0; end
    if (e_wgrant) begin w_hold = 1; dc_write_data = rnd_line(); end

    mem_res = 0; mem_res_addr = '0; mem_res_data = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mem_res = 1; mem_res_addr = cd_addr; mem_res_data = resp_data;
      end else if (cd == 1 && cd_bad) begin
        mem_res = 1; mem_res_addr = cd_addr + 4; mem_res_data = rnd_line();
      end
    end
    if (rand_on && cd == 0 && !mem_res && $urandom_range(0, 9) == 0) begin
      mem_res = 1; mem_res_addr = rnd_addr() | 32'h4; mem_res_data = rnd_line();
    end
    if (e_mem_req && resp_on) begin
      cd      = (resp_delay == 0) ? int'($urandom_range(1, 6)) : resp_delay;
      cd_addr = e_mem_req_addr;
      cd_bad  = (resp_bad_mode == 1) || (resp_bad_mode == 2 && $urandom_range(0, 3) == 0);
      if (resp_rand_data) resp_data = rnd_line();
    end

    if (rand_on) begin
      if (!ic_req && $urandom_range(0, 3) == 0) begin ic_req = 1; ic_req_addr = rnd_addr(); end
      else if (ic_req && !ic_hold && !e_ic_grant && $urandom_range(0, 15) == 0) ic_req = 0;
      if (!dc_req && $urandom_range(0, 3) == 0) begin dc_req = 1; dc_req_addr = rnd_addr(); end
      else if (dc_req && !dc_hold && !e_dc_grant && $urandom_range(0, 15) == 0) dc_req = 0;
      if (!dc_write && $urandom_range(0, 5) == 0) begin
        dc_write = 1; dc_write_addr = rnd_addr(); dc_write_data = rnd_line();
      end
    end
  endtask

  task automatic chk_comb();
    bit hit;
    hit = m_busy && (mem_res === 1'b1) && (mem_res_addr === m_addr);
    chk("ic_res",      L'(ic_res),      L'(hit && m_owner == IC));
    chk("ic_res_addr", L'(ic_res_addr), (hit && m_owner == IC) ? L'(mem_res_addr) : '0);
    chk("ic_res_data", ic_res_data,     (hit && m_owner == IC) ? mem_res_data : '0);
    chk("dc_res",      L'(dc_res),      L'(hit && m_owner == DC));
    chk("dc_res_addr", L'(dc_res_addr), (hit && m_owner == DC) ? L'(mem_res_addr) : '0);
    chk("dc_res_data", dc_res_data,     (hit && m_owner == DC) ? mem_res_data : '0);
    if (ic_res === 1'b1) begin icres_cyc.push_back(cyc); icres_data.push_back(ic_res_data); end
    if (dc_res === 1'b1) dc_res_cnt++;
  endtask

  task automatic chk_reg();
    chk("ic_grant",       L'(ic_grant),       L'(e_ic_grant));
    chk("dc_grant",       L'(dc_grant),       L'(e_dc_grant));
    chk("dc_wgrant",      L'(dc_wgrant),      L'(e_wgrant));
    chk("mem_req",        L'(mem_req),        L'(e_mem_req));
    chk("mem_req_addr",   L'(mem_req_addr),   L'(e_mem_req_addr));
    chk("mem_write",      L'(mem_write),      L'(e_mem_write));
    chk("mem_write_addr", L'(mem_write_addr), L'(e_mem_write_addr));
    chk("mem_write_data", mem_write_data,     e_mem_write_data);
    chk("timeout",        L'(timeout),        L'(e_timeout));
    chk("state",          L'(state_dbg),      L'(m_busy));
    if (mem_req === 1'b1) begin req_log.push_back(mem_req_addr); req_cyc.push_back(cyc); end
    if (mem_write === 1'b1) begin
      wr_addr_log.push_back(mem_write_addr); wr_data_log.push_back(mem_write_data);
      wr_cyc.push_back(cyc);
    end
    if (ic_grant === 1'b1) icg_cyc.push_back(cyc);
    if (timeout === 1'b1) to_cyc.push_back(cyc);
  endtask

  task automatic cycle();
    drive();
    #2;
    if (cyc > 0) chk_comb();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    chk_reg();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    for (int i = 0; i < budget && (ic_req || dc_req || dc_write || m_busy || cd > 0); i++) cycle();
    chk({tag, "_drained"}, L'({ic_req, dc_req, dc_write}), '0);
    chk({tag, "_idle"},    L'(state_dbg), '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t0;
    rst = 1;
    ic_req = 0; dc_req = 0; dc_write = 0;
    ic_req_addr = '0; dc_req_addr = '0; dc_write_addr = '0; dc_write_data = '0;
    mem_res = 0; mem_res_addr = '0; mem_res_data = '0;
    ic_hold = 0; dc_hold = 0; w_hold = 0; rand_on = 0; resp_on = 1; resp_rand_data = 0;
    resp_delay = 3; resp_bad_mode = 0; cd = 0; cd_bad = 0; cd_addr = '0; resp_data = '0;
    m_busy = 0; m_last = DC; m_owner = IC; m_addr = '0; m_issue_edge = 0;
    e_ic_grant = 0; e_dc_grant = 0; e_wgrant = 0; e_mem_req = 0; e_mem_write = 0; e_timeout = 0;
    e_mem_req_addr = '0; e_mem_write_addr = '0; e_mem_write_data = '0;
    clear_logs();

    // Reset: every registered output is zero afterwards
    cycle(); cycle();
    rst = 0;

    // Single I-cache read, memory answers 3 cycles after mem_req
    resp_data = 128'h7F;
    ic_req = 1; ic_req_addr = 32'd128;
    clear_logs();
    t0 = cyc;
    for (int i = 0; i < 20 && icres_cyc.size() == 0; i++) cycle();
    chk("r1_grant_latency", L'(icg_cyc.size() > 0 ? icg_cyc[0] - t0 : -1), L'(1));
    chk("r1_req_latency",   L'(req_cyc.size() > 0 ? req_cyc[0] - t0 : -1), L'(1));
    chk("r1_req_addr",      L'(req_log.size() > 0 ? req_log[0] : '0), L'(128));
    chk("r1_res_latency",   L'((icres_cyc.size() > 0 && req_cyc.size() > 0) ? icres_cyc[0] - req_cyc[0] : -1), L'(3));
    chk("r1_res_data",      icres_data.size() > 0 ? icres_data[0] : '0, 128'h7F);
    chk("r1_dc_res_none",   L'(dc_res_cnt), L'(0));
    run_until_idle("r1", 20);

    // Both readers raised from reset: I-cache first, then D-cache
    rst = 1;
    ic_req = 1; ic_req_addr = 32'd128;
    dc_req = 1; dc_req_addr = 32'd256;
    cycle();
    rst = 0;
    clear_logs();
    run_until_idle("rr", 60);
    chk("rr_count",  L'(req_log.size()), L'(2));
    chk("rr_first",  L'(req_log.size() > 0 ? req_log[0] : '0), L'(128));
    chk("rr_second", L'(req_log.size() > 1 ? req_log[1] : '0), L'(256));

    // Writeback and read raised together: the write goes first
    dc_write = 1; dc_write_addr = 32'd512; dc_write_data = 128'h12345678;
    ic_req = 1; ic_req_addr = 32'd128;
    clear_logs();
    run_until_idle("wr", 40);
    chk("wr_count",   L'(wr_cyc.size()), L'(1));
    chk("wr_addr",    L'(wr_addr_log.size() > 0 ? wr_addr_log[0] : '0), L'(512));
    chk("wr_data",    wr_data_log.size() > 0 ? wr_data_log[0] : '0, 128'h12345678);
    chk("wr_then_rd", L'((req_cyc.size() > 0 && wr_cyc.size() > 0) ? req_cyc[0] - wr_cyc[0] : -1), L'(1));

    // Mismatched response address is ignored, the matching one completes
    resp_bad_mode = 1; resp_data = 128'hABCD;
    ic_req = 1; ic_req_addr = 32'd128;
    clear_logs();
    run_until_idle("mm", 40);
    chk("mm_res_count", L'(icres_cyc.size()), L'(1));
    chk("mm_res_data",  icres_data.size() > 0 ? icres_data[0] : '0, 128'hABCD);
    resp_bad_mode = 0;

    // Reset while waiting: the late matching response is ignored
    resp_delay = 4;
    ic_req = 1; ic_req_addr = 32'd128;
    clear_logs();
    for (int i = 0; i < 10 && req_log.size() == 0; i++) cycle();
    cycle();
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 8; i++) cycle();
    chk("rst_res_none", L'(icres_cyc.size() + dc_res_cnt), L'(0));
    chk("rst_idle",     L'(state_dbg), L'(0));
    resp_delay = 3;

    // No response at all
    resp_on = 0;
    ic_req = 1; ic_req_addr = 32'h40;
    clear_logs();
    for (int i = 0; i < TIMEOUT + 10; i++) cycle();
`ifdef MEM_ARB_TIMEOUT_EN
    chk("to_count",   L'(to_cyc.size()), L'(1));
    chk("to_latency", L'((to_cyc.size() > 0 && req_cyc.size() > 0) ? to_cyc[0] - req_cyc[0] : -1), L'(TIMEOUT));
    resp_on = 1;
    ic_req = 1; ic_req_addr = 32'h80;
    for (int i = 0; i < 10 && icg_cyc.size() < 2; i++) cycle();
    chk("to_next_grant", L'(icg_cyc.size()), L'(2));
    run_until_idle("to", 40);
`else
    chk("to_never",      L'(to_cyc.size()), L'(0));
    chk("to_still_wait", L'(state_dbg), L'(1));
    resp_on = 1;
    rst = 1; cycle(); rst = 0;
`endif

    // Randomized traffic against the model
    rst = 1; cycle(); rst = 0;
    rand_on = 1; resp_delay = 0; resp_bad_mode = 2; resp_rand_data = 1;
    for (int i = 0; i < 800; i++) cycle();
    rand_on = 0;
    run_until_idle("rand", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
